// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode, instruction-field and FSM definitions for the pipe_ctrl
// fetch/execute/writeback pipeline.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_SUB  = 2'b01,
      OP_NOP  = 2'b10,
      OP_HALT = 2'b11
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int unsigned OP_MSB  = 31;
   localparam int unsigned OP_LSB  = 30;
   localparam int unsigned RD_MSB  = 29;
   localparam int unsigned RD_LSB  = 25;
   localparam int unsigned RS1_MSB = 24;
   localparam int unsigned RS1_LSB = 20;
   localparam int unsigned RS2_MSB = 19;
   localparam int unsigned RS2_LSB = 15;

   function automatic logic is_alu(input op_t op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// Read-after-write hazard detector between the execute and writeback stages.
module pipe_hazard_unit
   import pipe_ctrl_pkg::*;
(
   input  logic       ex_valid,
   input  op_t        ex_op,
   input  logic [4:0] ex_rs1,
   input  logic [4:0] ex_rs2,
   input  logic       wb_we,
   input  logic [4:0] wb_rd,
   output logic       stall
);

   always_comb begin
      stall = ex_valid && is_alu(ex_op) && wb_we && (wb_rd != '0) &&
              ((ex_rs1 == wb_rd) || (ex_rs2 == wb_rd));
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Three-stage fetch/execute/writeback controller with one-cycle hazard stall
// and HALT-driven drain.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [31:0]       fetch_inst,
   output logic [ADDR_W-1:0] pc,
   output logic              fetch_en,
   output logic              ex_valid,
   output logic [31:0]       ex_inst,
   output logic              wb_valid,
   output logic              wb_we,
   output logic [4:0]        wb_rd,
   output logic              stall,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  retire_cnt
);

   state_t     state;
   op_t        ex_op;
   logic [4:0] ex_rd;
   logic [4:0] ex_rs1;
   logic [4:0] ex_rs2;
   logic       ex_halt;

   always_comb begin
      ex_op    = op_t'(ex_inst[OP_MSB:OP_LSB]);
      ex_rd    = ex_inst[RD_MSB:RD_LSB];
      ex_rs1   = ex_inst[RS1_MSB:RS1_LSB];
      ex_rs2   = ex_inst[RS2_MSB:RS2_LSB];
      ex_halt  = ex_valid && (ex_op == OP_HALT);
      fetch_en = (state == ST_RUN) && !stall && !ex_halt;
      busy     = (state == ST_RUN) || (state == ST_DRAIN);
      done     = (state == ST_DONE);
   end

   pipe_hazard_unit u_hazard (
      .ex_valid (ex_valid),
      .ex_op    (ex_op),
      .ex_rs1   (ex_rs1),
      .ex_rs2   (ex_rs2),
      .wb_we    (wb_we),
      .wb_rd    (wb_rd),
      .stall    (stall)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         pc         <= '0;
         ex_valid   <= 1'b0;
         ex_inst    <= '0;
         wb_valid   <= 1'b0;
         wb_we      <= 1'b0;
         wb_rd      <= '0;
         retire_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state      <= ST_RUN;
                  pc         <= '0;
                  ex_valid   <= 1'b0;
                  ex_inst    <= '0;
                  wb_valid   <= 1'b0;
                  wb_we      <= 1'b0;
                  wb_rd      <= '0;
                  retire_cnt <= '0;
               end
            end
            ST_RUN, ST_DRAIN: begin
               if (wb_valid)
                  retire_cnt <= retire_cnt + 1'b1;

               // IF/EX holds its instruction through a stall, empties otherwise
               if (fetch_en) begin
                  ex_inst  <= fetch_inst;
                  ex_valid <= 1'b1;
                  pc       <= pc + 1'b1;
               end else if (!stall) begin
                  ex_valid <= 1'b0;
               end

               if (stall) begin
                  wb_valid <= 1'b0;
                  wb_we    <= 1'b0;
               end else begin
                  wb_valid <= ex_valid && !ex_halt;
                  wb_we    <= ex_valid && is_alu(ex_op);
                  wb_rd    <= ex_rd;
               end

               if ((state == ST_RUN) && ex_halt)
                  state <= ST_DRAIN;
               else if ((state == ST_DRAIN) && !wb_valid && !ex_valid)
                  state <= ST_DONE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: program-level reference model, retire
// queue checked by an independent monitor.
module tb_pipe_ctrl;

   localparam int NOP_OP  = 2;
   localparam int HALT_OP = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] fetch_inst;
   logic [4:0]  pc;
   logic        fetch_en;
   logic        ex_valid;
   logic [31:0] ex_inst;
   logic        wb_valid;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic        stall;
   logic        busy;
   logic        done;
   logic [7:0]  retire_cnt;

   pipe_ctrl #(.ADDR_W(5), .CNT_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .fetch_inst (fetch_inst),
      .pc         (pc),
      .fetch_en   (fetch_en),
      .ex_valid   (ex_valid),
      .ex_inst    (ex_inst),
      .wb_valid   (wb_valid),
      .wb_we      (wb_we),
      .wb_rd      (wb_rd),
      .stall      (stall),
      .busy       (busy),
      .done       (done),
      .retire_cnt (retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       we;
      logic [4:0] rd;
   } wb_t;

   int          total = 0;
   int          bad = 0;
   int          stall_seen = 0;
   int          plen = 0;
   int          fidx;
   logic [31:0] prog [0:63];
   wb_t         exp_q [$];

   function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2);
      logic [14:0] junk;
      junk = 15'($urandom);
      return {op[1:0], rd[4:0], rs1[4:0], rs2[4:0], junk};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Instruction supply indexed by fetch number, so programs may outrun pc wrap.
   always_comb fetch_inst = (fidx < plen) ? prog[fidx] : 32'h8000_0000;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)               fidx <= 0;
      else if (start && !busy)  fidx <= 0;
      else if (fetch_en)        fidx <= fidx + 1;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         wb_t e;
         if (stall) stall_seen++;
         check("we_without_valid", {31'b0, wb_we && !wb_valid}, 32'd0);
         if (fetch_en) check("fetch_pc", {27'b0, pc}, fidx % 32);
         if (wb_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_retire: got wb_rd=%0d want none", wb_rd);
            end else begin
               e = exp_q.pop_front();
               check("wb_we", {31'b0, wb_we}, {31'b0, e.we});
               check("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
            end
         end
      end
   end

   // Model: every non-HALT instruction retires in order; an ALU op stalls once
   // when its predecessor is an ALU op writing a nonzero register it reads.
   task automatic prepare(input int n, output int stalls);
      int op, pop, prd;
      prog[n] = mk(HALT_OP, 0, 0, 0);
      plen    = n + 1;
      stalls  = 0;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         op = int'(prog[i][31:30]);
         exp_q.push_back('{we: (op != NOP_OP), rd: prog[i][29:25]});
         if (i > 0) begin
            pop = int'(prog[i-1][31:30]);
            prd = int'(prog[i-1][29:25]);
            if (op < 2 && pop < 2 && prd != 0 &&
                (prd == int'(prog[i][24:20]) || prd == int'(prog[i][19:15])))
               stalls++;
         end
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run(input string tag, input int n, input bit poke_drain);
      int  stalls, cyc, s0;
      bit  poked;
      prepare(n, stalls);
      pulse_start();
      s0 = stall_seen;
      check({tag, "_cnt_cleared"}, {24'b0, retire_cnt}, 32'd0);
      check({tag, "_pc_cleared"}, {27'b0, pc}, 32'd0);
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      cyc   = 0;
      poked = 1'b0;
      while (!done && cyc < 300) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         cyc++;
         if (poke_drain && !poked && busy && !fetch_en && !ex_valid) begin
            start = 1'b1;
            poked = 1'b1;
         end
      end
      start = 1'b0;
      check({tag, "_cycles"}, cyc, n + 3 + stalls);
      check({tag, "_stalls"}, stall_seen - s0, stalls);
      check({tag, "_retire_cnt"}, {24'b0, retire_cnt}, (n % 256));
      check({tag, "_pc_final"}, {27'b0, pc}, (n + 1) % 32);
      check({tag, "_idle_outs"}, {27'b0, fetch_en, ex_valid, wb_valid, stall, busy}, 32'd0);
      check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
      if (poke_drain) check({tag, "_drain_poked"}, {31'b0, poked}, 32'd1);
   endtask

   initial begin
      int  n, stalls;
      bit  seen;
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check("reset_outs", {pc, fetch_en, ex_valid, wb_valid, wb_we, wb_rd, stall, busy, done, retire_cnt},
            32'd0);
      check("reset_ex_inst", ex_inst, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      prog[0] = mk(0, 3, 1, 2);
      prog[1] = mk(1, 1, 2, 2);
      run("basic", 2, 1'b0);

      prog[0] = mk(0, 3, 1, 2);
      prog[1] = mk(1, 4, 3, 1);
      run("hazard", 2, 1'b0);

      prog[0] = mk(0, 0, 1, 2);
      prog[1] = mk(1, 4, 0, 0);
      run("r0_dest", 2, 1'b0);

      for (int i = 0; i < 33; i++) prog[i] = mk(NOP_OP, i % 32, 1, 2);
      run("nop_wrap", 33, 1'b0);

      // Reset while writes are in flight.
      for (int i = 0; i < 20; i++) prog[i] = mk(0, 5, 6, 7);
      prepare(20, stalls);
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = wb_we;
      end
      check("rst_saw_we", {31'b0, seen}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_outs", {pc, fetch_en, ex_valid, wb_valid, wb_we, wb_rd, stall, busy, done, retire_cnt},
            32'd0);
      check("rst_async_ex_inst", ex_inst, 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("rst_no_restart", {30'b0, busy, done}, 32'd0);
      rst_n = 1'b1;
      prog[0] = mk(0, 3, 1, 2);
      prog[1] = mk(1, 1, 2, 2);
      run("after_reset", 2, 1'b0);

      prog[0] = mk(0, 2, 1, 1);
      prog[1] = mk(0, 3, 2, 2);
      prog[2] = mk(1, 4, 3, 0);
      run("drain_poke", 3, 1'b1);
      run("restart", 3, 1'b0);

      for (int t = 0; t < 12; t++) begin
         n = $urandom_range(1, 25);
         for (int i = 0; i < n; i++)
            prog[i] = mk($urandom_range(0, 2), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
         run("random", n, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter ADDR_W, default 5, instruction-memory address width.
REQ-002 Parameter CNT_W, default 8, width of the retire counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  launch program from address 0; sampled only in IDLE or DONE.
REQ-006 fetch_inst  input  32  instruction word at pc: [31:30] op, [29:25] rd, [24:20] rs1, [19:15] rs2, [14:0] unused.
REQ-007 pc  output  ADDR_W  fetch address.
REQ-008 fetch_en  output  1  fetch_inst captured at this edge.
REQ-009 ex_valid  output  1  IF/EX register holds a live instruction.
REQ-010 ex_inst  output  32  IF/EX instruction to the execute stage.
REQ-011 wb_valid  output  1  EX/WB register holds a live instruction.
REQ-012 wb_we  output  1  register-file write enable for the writeback stage.
REQ-013 wb_rd  output  5  writeback destination register.
REQ-014 stall  output  1  hazard stall this cycle.
REQ-015 busy  output  1  state is RUN or DRAIN.
REQ-016 done  output  1  state is DONE.
REQ-017 retire_cnt  output  CNT_W  instructions retired since last start.

Function
REQ-018 Opcodes SHALL be ADD=2'b00, SUB=2'b01 (both write rd), NOP=2'b10 (no write), HALT=2'b11.
REQ-019 FSM SHALL have states IDLE, RUN, DRAIN, DONE; IDLE/DONE + start -> RUN, which clears pc, both stage registers and retire_cnt.
REQ-020 start in RUN or DRAIN SHALL be ignored.
REQ-021 fetch_en SHALL equal (state==RUN) & !stall & !(ex_valid & ex op==HALT), combinationally.
REQ-022 On an edge with fetch_en=1: IF/EX <= {fetch_inst, valid=1}, pc <= pc+1, wrapping 2^ADDR_W-1 -> 0.
REQ-023 stall SHALL be 1 iff ex_valid & ex op in {ADD,SUB} & wb_we & wb_rd!=0 & (ex rs1==wb_rd | ex rs2==wb_rd).
REQ-024 During stall: pc and IF/EX held, EX/WB loaded with a bubble (wb_valid=0, wb_we=0); stall lasts exactly one cycle per hazard.
REQ-025 Without stall, EX/WB SHALL load from IF/EX: wb_valid=ex_valid & op!=HALT, wb_we=wb_valid & op in {ADD,SUB}, wb_rd=ex rd.
REQ-026 When not fetching and not stalling, IF/EX valid SHALL clear.
REQ-027 HALT in IF/EX SHALL move RUN -> DRAIN at the next edge; HALT never reaches writeback or counts as retired.
REQ-028 DRAIN -> DONE on the first edge where wb_valid=0 and ex_valid=0.
REQ-029 retire_cnt SHALL increment on every edge with wb_valid=1, wrapping at 2^CNT_W.
REQ-030 In IDLE and DONE all stage valids, wb_we, stall and fetch_en SHALL be 0; pc and retire_cnt hold.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, pc=0, ex_valid=0, ex_inst=0, wb_valid=0, wb_we=0, wb_rd=0, retire_cnt=0; all outputs derived accordingly 0.
REQ-032 Reset asserted mid-RUN SHALL abandon in-flight instructions with no write enable pulse; operation resumes only on a new start.

Structure
REQ-033 Opcode constants, instruction field positions and FSM state encoding SHALL reside in a shared package used by pipe_ctrl and the fetch/execute/writeback stages.
REQ-034 Hazard detection SHALL be a combinational sub-module pipe_hazard_unit.

Verification
REQ-035 ADD r3,r1,r2; SUB r1,r2,r2; HALT -> stall never 1, done=1 on 5th edge after start sampled, retire_cnt=2, pc=3.
REQ-036 ADD r3,r1,r2; SUB r4,r3,r1; HALT -> stall=1 for exactly one cycle with pc=2 held, one bubble in WB, retire_cnt=2.
REQ-037 ADD r0,r1,r2; SUB r4,r0,r0; HALT -> no stall, first wb_we=1 with wb_rd=0, retire_cnt=2.
REQ-038 Bench supplies 33 NOPs then HALT -> pc goes 31 -> 0, wb_we never 1, retire_cnt=33.
REQ-039 rst_n low during RUN with wb_we=1 -> all outputs 0 asynchronously; after release plus start, pc restarts at 0 and retire_cnt counts from 0.
REQ-040 start pulsed during DRAIN -> ignored; DONE then start -> RUN, retire_cnt cleared.
